// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a fixed, parameterised access latency.
// Optional performance counters are built when DMEM_PERF_CNT_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic          acc_err;
  logic          mem_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;

  // With LATENCY=1 the access edge is the accept edge, so use live inputs then.
  always_comb begin
    acc_addr  = (state_q == S_IDLE) ? addr_i  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? wdata_i : wdata_q;
    acc_we    = (state_q == S_IDLE) ? we_i    : we_q;
    acc_idx   = acc_addr[AW+1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = we_i;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CW'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      err_d = acc_err;
      if (!acc_we) rdata_d = acc_err ? '0 : mem[acc_idx];
    end
  end

  // Gate on reset so a request in flight when reset hits never commits.
  assign mem_we = enter_resp && acc_we && !acc_err && rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = err_q;
  assign rdata_o      = rdata_q;
  assign stall_o      = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_WAIT);

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && !we_i) rd_cnt_d = rd_cnt_q + 32'(1);
    if (accept && we_i)  wr_cnt_d = wr_cnt_q + 32'(1);
    if (stall_o)         stall_cnt_d = stall_cnt_q + 32'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=3 instance plus a LATENCY=1 instance.
// Counter checks are compiled in when DMEM_PERF_CNT_EN is defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, we;
  logic [31:0] addr, wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] rdata;

  logic        v1, we1;
  logic [31:0] a1, d1;
  logic        r1_ready, r1_valid, r1_err, r1_stall;
  logic [31:0] r1_rdata;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt, wr_cnt, stall_cnt;
  logic [31:0] rd_cnt1, wr_cnt1, stall_cnt1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .resp_valid_o(resp_valid), .rdata_o(rdata), .resp_err_o(resp_err),
    .stall_o(stall)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(v1), .req_ready_o(r1_ready),
    .we_i(we1), .addr_i(a1), .wdata_i(d1),
    .resp_valid_o(r1_valid), .rdata_o(r1_rdata), .resp_err_o(r1_err),
    .stall_o(r1_stall)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1), .stall_cnt_o(stall_cnt1)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=3 transaction, accept in cycle 0, response in cycle 3.
  // Garbage is driven during WAIT to confirm the latched request is kept.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    req_valid = 1'b1; we = w; addr = a; wdata = d;
    #1;
    chk1({tag, ".c0_ready"}, req_ready, 1'b1);
    chk1({tag, ".c0_stall"}, stall, 1'b1);
    chk1({tag, ".c0_resp"}, resp_valid, 1'b0);
    cyc();
    we = ~w; addr = 32'h0000_0044; wdata = 32'h5555_5555;
    #1;
    chk1({tag, ".c1_ready"}, req_ready, 1'b0);
    chk1({tag, ".c1_stall"}, stall, 1'b1);
    chk1({tag, ".c1_resp"}, resp_valid, 1'b0);
    cyc();
    req_valid = 1'b0;
    #1;
    chk1({tag, ".c2_stall"}, stall, 1'b1);
    chk1({tag, ".c2_resp"}, resp_valid, 1'b0);
    cyc();
    chk1({tag, ".c3_resp"}, resp_valid, 1'b1);
    chk1({tag, ".c3_stall"}, stall, 1'b0);
    chk1({tag, ".c3_ready"}, req_ready, 1'b0);
    chk1({tag, ".c3_err"}, resp_err, exp_err);
    chk32({tag, ".c3_rdata"}, rdata, exp_rd);
    cyc();
    chk1({tag, ".c4_resp"}, resp_valid, 1'b0);
    chk1({tag, ".c4_ready"}, req_ready, 1'b1);
    chk1({tag, ".c4_stall"}, stall, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk1("rst.ready", req_ready, 1'b1);
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.resp", resp_valid, 1'b0);
    chk1("rst.err", resp_err, 1'b0);
    chk32("rst.rdata", rdata, 32'h0);
    chk1("rst.ready1", r1_ready, 1'b1);
    cyc();

    txn("pre20", 1'b1, 32'h20, 32'h0000_0001, 32'h0, 1'b0);
    txn("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("wr13", 1'b1, 32'h13, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1);
    txn("rd10b", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("rd400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    txn("wr14", 1'b1, 32'h14, 32'h1234_5678, 32'h0, 1'b0);
    txn("rd14", 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0);

    // LATENCY=1: write accepted in cycle 0, read offered in 1 (ignored), accepted in 2.
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h8; d1 = 32'hA5A5_A5A5;
    #1;
    chk1("l1.c0_ready", r1_ready, 1'b1);
    chk1("l1.c0_stall", r1_stall, 1'b1);
    chk1("l1.c0_resp", r1_valid, 1'b0);
    cyc();
    we1 = 1'b0; a1 = 32'h8; d1 = 32'h0;
    #1;
    chk1("l1.c1_resp", r1_valid, 1'b1);
    chk1("l1.c1_ready", r1_ready, 1'b0);
    chk1("l1.c1_stall", r1_stall, 1'b0);
    chk1("l1.c1_err", r1_err, 1'b0);
    cyc();
    chk1("l1.c2_ready", r1_ready, 1'b1);
    chk1("l1.c2_stall", r1_stall, 1'b1);
    chk1("l1.c2_resp", r1_valid, 1'b0);
    cyc();
    v1 = 1'b0;
    #1;
    chk1("l1.c3_resp", r1_valid, 1'b1);
    chk32("l1.c3_rdata", r1_rdata, 32'hA5A5_A5A5);
    cyc();
    chk1("l1.c4_resp", r1_valid, 1'b0);
    chk32("l1.c4_rdata_hold", r1_rdata, 32'hA5A5_A5A5);

    // Reset during WAIT of a write to 0x20 must discard the write.
    req_valid = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hBAD0_BAD0;
    #1;
    chk1("rw.c0_stall", stall, 1'b1);
    cyc();
    req_valid = 1'b0;
    #1;
    chk1("rw.c1_ready", req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rw.rst_ready", req_ready, 1'b1);
    chk1("rw.rst_stall", stall, 1'b0);
    chk1("rw.rst_resp", resp_valid, 1'b0);
    chk32("rw.rst_rdata", rdata, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("rw.no_resp", resp_valid, 1'b0);
    end
    txn("rd20", 1'b0, 32'h20, 32'h0, 32'h0000_0001, 1'b0);

`ifdef DMEM_PERF_CNT_EN
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk32("pc.rd0", rd_cnt, 32'd0);
    chk32("pc.wr0", wr_cnt, 32'd0);
    chk32("pc.st0", stall_cnt, 32'd0);
    cyc();
    txn("pc_rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("pc_rd20", 1'b0, 32'h20, 32'h0, 32'h0000_0001, 1'b0);
    txn("pc_wr24", 1'b1, 32'h24, 32'h7, 32'h0000_0001, 1'b0);
    chk32("pc.rd", rd_cnt, 32'd2);
    chk32("pc.wr", wr_cnt, 32'd1);
    chk32("pc.st", stall_cnt, 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's MEM-stage data port, paired with the pipeline's load/store initiator.
- Accepts one read or write request at a time and holds it for LATENCY cycles to model a slow memory.
- Returns read data or a write completion with a one-cycle response pulse.
- Drives a stall to the pipeline for the whole time a request is outstanding.
- Sits between EX_MEM/MEM_WB and a word-addressed 32-bit storage array that it owns.

Parameters:
- DEPTH, 256, number of 32-bit words in the storage array; power of two, 16..4096.
- LATENCY, 3, cycles from the accept cycle to the response cycle; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present this cycle.
- req_ready_o  out  1  responder can accept a request; high only in IDLE.
- we_i  in  1  1 = write (store), 0 = read (load).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
- resp_valid_o  out  1  one-cycle response pulse.
- rdata_o  out  32  load data; valid while resp_valid_o is high.
- resp_err_o  out  1  error flag; qualified by resp_valid_o.
- stall_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, latency counter = 0.
  - rdata_o = 0, resp_valid_o = 0, resp_err_o = 0.
  - Any in-flight request is discarded and its write is never committed.
  - Storage contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i = 1 (the accept cycle): latch addr_i, we_i and wdata_i, then go to RESP if LATENCY = 1, otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready_o = 0.
  - Counter decrements each cycle.
  - When counter = 1, the next state is RESP.
- Entry into RESP (the clock edge that enters RESP):
  - Access is performed on this edge.
  - Write: mem[word] <= latched wdata.
  - Read: rdata_o <= mem[word].
- RESP:
  - resp_valid_o = 1 for exactly one cycle, then go to IDLE.
  - No new request is accepted in RESP.
- Latency: resp_valid_o is high exactly LATENCY cycles after the accept cycle.
- Throughput: one request per LATENCY+1 cycles.
- Address decode:
  - word index = addr[log2(DEPTH)+1:2].
  - Error condition: addr[1:0] != 0, or addr[31:log2(DEPTH)+2] != 0.
  - On error: the write is suppressed, rdata_o = 0, and resp_err_o = 1 in the RESP cycle.
  - Without error, resp_err_o = 0.
- stall_o (combinational):
  - 1 in IDLE when req_valid_i = 1.
  - 1 throughout WAIT.
  - 0 in RESP, so the pipeline advances and captures rdata_o in that cycle.
- rdata_o holds its value after RESP until the next read response or reset.
- req_valid_i, we_i, addr_i and wdata_i are ignored outside IDLE; input changes during WAIT do not affect the latched request.
- A read in the request immediately after a write to the same address returns the new data.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined — the block adds three output ports:
  - rd_cnt_o, 32 bits: count of accepted reads.
  - wr_cnt_o, 32 bits: count of accepted writes, including errored ones.
  - stall_cnt_o, 32 bits: count of cycles with stall_o = 1.
  - Counters are reset to 0 by rst_i, increment in the accept cycle (stall_cnt_o each stalled cycle), and wrap at 2^32.
- Undefined: these ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> req_ready_o = 1, stall_o = 0, resp_valid_o = 0, rdata_o = 0.
- LATENCY=3: write addr 0x10, data 0xDEADBEEF in cycle 0 -> stall_o high in cycles 0-2, resp_valid_o high in cycle 3 only, resp_err_o = 0. Then read 0x10 in cycle 4 -> rdata_o = 0xDEADBEEF in cycle 7.
- LATENCY=1: read accepted in cycle 0 -> resp_valid_o high in cycle 1. The next request is accepted in cycle 2; req_ready_o = 0 in cycle 1.
- Misaligned write to 0x13, then read 0x10 -> resp_err_o = 1 for the write, and the read returns the prior contents unchanged. Read 0x400 with DEPTH=256 -> resp_err_o = 1, rdata_o = 0.
- rst_i pulsed low during WAIT of a write to 0x20 (old value 0x1) -> immediate IDLE, resp_valid_o never pulses, and a later read of 0x20 returns 0x1.
- With DMEM_PERF_CNT_EN, LATENCY=3, two reads and one write -> rd_cnt_o = 2, wr_cnt_o = 1, stall_cnt_o = 9.
